// File: rtl/player_hit_edge_detect_if.sv
// rtl/player_hit_edge_detect_if.sv - raster/collision signal bundle for player_hit_edge_detect
// HIT_COUNT_EN adds the hitCount return signal.
interface player_hit_edge_detect_if;
  logic               startOfFrame;
  logic        [10:0] pixelX;
  logic        [10:0] pixelY;
  logic signed [10:0] playerTopLeftX;
  logic signed [10:0] playerTopLeftY;
  logic               playerDR;
  logic               wallDR;
  logic               collision;
  logic        [3:0]  HitEdgeCode;
  logic               collisionPulse;
`ifdef HIT_COUNT_EN
  logic        [7:0]  hitCount;
`endif

  modport master (
    output startOfFrame, pixelX, pixelY, playerTopLeftX, playerTopLeftY, playerDR, wallDR,
`ifdef HIT_COUNT_EN
    input  hitCount,
`endif
    input  collision, HitEdgeCode, collisionPulse
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, playerTopLeftX, playerTopLeftY, playerDR, wallDR,
`ifdef HIT_COUNT_EN
    output hitCount,
`endif
    output collision, HitEdgeCode, collisionPulse
  );
endinterface

// File: rtl/player_hit_edge_detect.sv
// rtl/player_hit_edge_detect.sv - per-frame player/wall overlap classifier by player box edge
// HIT_COUNT_EN adds a saturating per-frame overlap pixel counter on hitCount.
module player_hit_edge_detect #(
  parameter int OBJECT_WIDTH_X = 64,
  parameter int OBJECT_HIGHT_Y = 64,
  parameter int EDGE_MARGIN    = 4
) (
  input logic                   clk,
  input logic                   reset,
  player_hit_edge_detect_if.slave bus
);
  localparam logic signed [11:0] BOX_W   = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] BOX_H   = 12'(OBJECT_HIGHT_Y);
  localparam logic signed [11:0] MARGIN  = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_B = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_B = 12'(OBJECT_HIGHT_Y - EDGE_MARGIN);

  typedef enum logic {SYNC_ST, ACC_ST} state_t;
  state_t state, state_next;
  logic   accepting, latch;

  logic               hit1;
  logic signed [11:0] off_x, off_y, diff_x, diff_y;
  logic               in_box, hit2;
  logic        [3:0]  edges;

  logic        [3:0]  acc_edge, edge_out;
  logic               acc_hit, coll_out, pulse_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC_ST;
    else       state <= state_next;
  end

  // Only the first startOfFrame after reset matters; from then on every frame is whole.
  always_comb begin
    state_next = state;
    if (state == SYNC_ST && bus.startOfFrame) state_next = ACC_ST;
  end

  always_comb begin
    accepting = (state == ACC_ST);
    latch     = accepting && bus.startOfFrame;
  end

  always_comb begin
    diff_x = {1'b0, bus.pixelX} - {bus.playerTopLeftX[10], bus.playerTopLeftX};
    diff_y = {1'b0, bus.pixelY} - {bus.playerTopLeftY[10], bus.playerTopLeftY};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1  <= 1'b0;
      off_x <= '0;
      off_y <= '0;
    end else begin
      hit1  <= bus.playerDR && bus.wallDR && (accepting || bus.startOfFrame);
      off_x <= diff_x;
      off_y <= diff_y;
    end
  end

  // Overlap outside the player box is a renderer artefact and is dropped entirely.
  always_comb begin
    in_box = !off_x[11] && !off_y[11] && (off_x < BOX_W) && (off_y < BOX_H);
    hit2   = hit1 && in_box;
    edges  = {off_x < MARGIN, off_y < MARGIN, off_x >= RIGHT_B, off_y >= BOTTOM_B} & {4{hit2}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_edge  <= '0;
      acc_hit   <= 1'b0;
      edge_out  <= '0;
      coll_out  <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      if (latch) begin
        edge_out  <= acc_edge | edges;
        coll_out  <= acc_hit | hit2;
        pulse_out <= acc_hit | hit2;
        acc_edge  <= '0;
        acc_hit   <= 1'b0;
      end else if (accepting) begin
        acc_edge  <= acc_edge | edges;
        acc_hit   <= acc_hit | hit2;
      end
    end
  end

  assign bus.HitEdgeCode    = edge_out;
  assign bus.collision      = coll_out;
  assign bus.collisionPulse = pulse_out;

`ifdef HIT_COUNT_EN
  logic [7:0] acc_cnt, cnt_out, cnt_next;

  always_comb begin
    cnt_next = acc_cnt;
    if (hit2 && acc_cnt != 8'hFF) cnt_next = acc_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt <= '0;
      cnt_out <= '0;
    end else if (latch) begin
      cnt_out <= cnt_next;
      acc_cnt <= '0;
    end else if (accepting) begin
      acc_cnt <= cnt_next;
    end
  end

  assign bus.hitCount = cnt_out;
`endif
endmodule

// File: tb/tb_player_hit_edge_detect.sv
// tb/tb_player_hit_edge_detect.sv - self-checking bench for player_hit_edge_detect
// Frame-level reference model plus directed literal checks; HIT_COUNT_EN adds hitCount checks.
module tb_player_hit_edge_detect;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_hit_edge_detect_if bus ();
  player_hit_edge_detect dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int W = 64, H = 64, M = 4;

  int total = 0;
  int bad   = 0;

  // Frame-level model: hits from cycles [previous SOF, this SOF) form one reported frame.
  bit       armed   = 0;
  logic [3:0] fr_edge = '0;
  bit       fr_hit  = 0;
  int       fr_cnt  = 0;
  logic [3:0] exp_edge = '0;
  logic     exp_coll = 1'b0;
  logic     exp_pulse = 1'b0;
  int       exp_cnt = 0;
  int       tlx = 100, tly = 100;
  bit       checking = 0;

  function automatic int wrap12(int v);
    int r;
    r = v & 'hFFF;
    if (r >= 2048) r = r - 4096;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic clear_model();
    armed = 0; fr_edge = '0; fr_hit = 0; fr_cnt = 0;
    exp_edge = '0; exp_coll = 1'b0; exp_pulse = 1'b0; exp_cnt = 0;
  endtask

  task automatic step(input bit sof, input int px, input int py, input bit pd, input bit wd);
    int dx, dy;
    @(negedge clk);
    bus.startOfFrame   = sof;
    bus.pixelX         = 11'(px);
    bus.pixelY         = 11'(py);
    bus.playerTopLeftX = 11'(tlx);
    bus.playerTopLeftY = 11'(tly);
    bus.playerDR       = pd;
    bus.wallDR         = wd;
    exp_pulse = 1'b0;
    if (sof && armed) begin
      exp_edge  = fr_edge;
      exp_coll  = fr_hit;
      exp_pulse = fr_hit;
      exp_cnt   = (fr_cnt > 255) ? 255 : fr_cnt;
      fr_edge = '0; fr_hit = 0; fr_cnt = 0;
    end
    if (sof) armed = 1;
    if (armed && pd && wd) begin
      dx = wrap12(px - tlx);
      dy = wrap12(py - tly);
      if (dx >= 0 && dx < W && dy >= 0 && dy < H) begin
        fr_hit = 1;
        fr_cnt++;
        fr_edge = fr_edge | {dx < M, dy < M, dx >= W - M, dy >= H - M};
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    repeat (3) begin
      bus.startOfFrame = 1'b0;
      bus.pixelX = 11'(tlx + 5);
      bus.pixelY = 11'(tly + 5);
      bus.playerDR = 1'b1;
      bus.wallDR = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    bus.playerDR = 1'b0;
    bus.wallDR = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [3:0] edge_w, input logic coll_w, input logic pulse_w);
    check({name, ".edge"}, 32'(bus.HitEdgeCode), 32'(edge_w));
    check({name, ".coll"}, 32'(bus.collision), 32'(coll_w));
    check({name, ".pulse"}, 32'(bus.collisionPulse), 32'(pulse_w));
  endtask

  task automatic frame_with_hit(input int px, input int py);
    step(0, px, py, 1, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    after_edge();
  endtask

  // Compare process: DUT against the model on every cycle.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      check("model.edge", 32'(bus.HitEdgeCode), 32'(exp_edge));
      check("model.coll", 32'(bus.collision), 32'(exp_coll));
      check("model.pulse", 32'(bus.collisionPulse), 32'(exp_pulse));
`ifdef HIT_COUNT_EN
      check("model.count", 32'(bus.hitCount), 32'(exp_cnt));
`endif
    end
  end

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.pixelX = '0; bus.pixelY = '0;
    bus.playerTopLeftX = 11'(tlx); bus.playerTopLeftY = 11'(tly);
    bus.playerDR = 1'b0; bus.wallDR = 1'b0;
    checking = 1;
    reset_dut();
    after_edge();
    lit("reset", 4'b0000, 1'b0, 1'b0);

    // Partial frame after reset is never reported.
    step(0, 110, 110, 1, 1);
    step(1, 0, 0, 0, 0);
    after_edge();
    lit("sync", 4'b0000, 1'b0, 1'b0);

    frame_with_hit(100, 130);
    lit("left", 4'b1000, 1'b1, 1'b1);
    step(0, 0, 0, 0, 0);
    after_edge();
    lit("hold", 4'b1000, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0);
    after_edge();
    lit("clean", 4'b0000, 1'b0, 1'b0);

    frame_with_hit(163, 163);
    lit("br_corner", 4'b0011, 1'b1, 1'b1);
    frame_with_hit(100, 100);
    lit("tl_corner", 4'b1100, 1'b1, 1'b1);
    frame_with_hit(132, 132);
    lit("interior", 4'b0000, 1'b1, 1'b1);
    frame_with_hit(50, 50);
    lit("outside", 4'b0000, 1'b0, 1'b0);

    // Hit in the SOF cycle belongs to the new frame.
    step(1, 100, 130, 1, 1);
    after_edge();
    lit("sof_hit_now", 4'b0000, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    after_edge();
    lit("sof_hit_next", 4'b1000, 1'b1, 1'b1);

    // Back-to-back SOF: second latch sees only the pixel that was in flight.
    step(0, 163, 163, 1, 1);
    step(1, 100, 130, 1, 1);
    after_edge();
    lit("dbl_sof1", 4'b0011, 1'b1, 1'b1);
    step(1, 0, 0, 0, 0);
    after_edge();
    lit("dbl_sof2", 4'b1000, 1'b1, 1'b1);

`ifdef HIT_COUNT_EN
    for (int i = 0; i < 300; i++) step(0, 132, 132, 1, 1);
    step(1, 0, 0, 0, 0);
    after_edge();
    check("count_sat", 32'(bus.hitCount), 32'd255);
    for (int i = 0; i < 7; i++) step(0, 101 + i, 140, 1, 1);
    step(1, 0, 0, 0, 0);
    after_edge();
    check("count_7", 32'(bus.hitCount), 32'd7);
    for (int i = 0; i < 5; i++) step(0, 120, 120, 1, 1);
    reset_dut();
    after_edge();
    check("count_reset", 32'(bus.hitCount), 32'd0);
`endif

    // Randomized traffic against the model, with occasional moves and resets.
    for (int c = 0; c < 4000; c++) begin
      int px, py;
      if (c % 200 == 0) begin
        tlx = int'($urandom_range(0, 220)) - 20;
        tly = int'($urandom_range(0, 220)) - 20;
      end
      if ($urandom_range(0, 299) == 0) begin
        reset_dut();
      end else begin
        px = tlx + int'($urandom_range(0, 80)) - 8;
        py = tly + int'($urandom_range(0, 80)) - 8;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        step($urandom_range(0, 39) == 0, px, py, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      end
    end
    step(1, 0, 0, 0, 0);
    after_edge();
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
